puf_challenge_sequencer: RTL and testbench
==========================================

PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Interface
REQ-001 Parameter RESP_BITS, default 16: number of response bits collected per request (2..32).
REQ-002 Parameter CLEAR_CYCLES, default 4: cycles sub_reset is held per bit (minimum 3).
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000: RUN-state cycles allowed per bit before abort; 20-bit timer.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 seed  input  8  initial challenge; latched on accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 sub_enable  output  32  ring-oscillator enables to the PUF subblock.
REQ-010 sub_challenge  output  8  mux selects to the subblock; [3:0] first bank, [7:4] second bank.
REQ-011 sub_reset  output  1  active-high clear of the subblock counters and arbiter.
REQ-012 sub_out  input  1  subblock race result; asynchronous to clock.
REQ-013 sub_done  input  1  subblock race-finished flag; asynchronous to clock.
REQ-014 response  output  RESP_BITS  collected response word.
REQ-015 resp_valid  output  1  response word complete and stable.
REQ-016 resp_ready  input  1  consumer accepts response.
REQ-017 timeout_err  output  1  sticky per request; at least one bit timed out.

Function
REQ-018 sub_out and sub_done SHALL each pass through a 2-flop synchronizer; only the synchronized versions (done_s, out_s) are used.
REQ-019 States SHALL be IDLE, CLEAR, RUN, NEXT, HOLD; all outputs registered.
REQ-020 IDLE: start=1 latches challenge <= seed (seed 8'h00 replaced by 8'h01), bit_cnt <= 0, response <= 0, timeout_err <= 0; next state CLEAR.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 CLEAR: sub_reset=1, sub_enable=0; held exactly CLEAR_CYCLES cycles; then RUN with timer cleared.
REQ-023 RUN: sub_reset=0, sub_enable=32'hFFFF_FFFF, timer increments each cycle.
REQ-024 RUN, done_s=1: response <= {response[RESP_BITS-2:0], out_s} (first bit ends at MSB); next NEXT.
REQ-025 RUN, timer = TIMEOUT_CYCLES-1 with done_s=0: shift in 0, set timeout_err; next NEXT.
REQ-026 If done_s rises on the timeout cycle, REQ-024 SHALL take priority (no error).
REQ-027 NEXT: sub_enable=0, sub_reset=0; challenge <= {c[6:0], c[7]^c[5]^c[4]^c[3]}; bit_cnt increments; if old bit_cnt = RESP_BITS-1 go HOLD, else CLEAR.
REQ-028 sub_challenge SHALL equal the challenge register and change only in NEXT or on accepted start.
REQ-029 HOLD: resp_valid=1, response and timeout_err stable; resp_ready=1 moves to IDLE and resp_valid is 0 the following cycle.
REQ-030 resp_valid SHALL be 0 in every state other than HOLD.
REQ-031 Per-bit latency: CLEAR_CYCLES + (race cycles + 2 sync) + 1 NEXT cycle.

Reset
REQ-032 reset=0 SHALL asynchronously force IDLE, busy=0, sub_enable=0, sub_challenge=0, sub_reset=1, response=0, resp_valid=0, timeout_err=0, bit_cnt=0, timer=0, synchronizers=0.
REQ-033 Reset asserted mid-request SHALL abandon the request; no resp_valid is produced for it.
REQ-034 After reset release, outputs hold reset values until the first accepted start, except sub_reset, which SHALL fall to 0 in IDLE on the first clock edge.

Verification
REQ-035 Seed 0x01, subblock model done 10 cycles after enable, out=1 -> sub_challenge sequence 01,02,04,08,11...; response=16'hFFFF; timeout_err=0.
REQ-036 Seed 0x00 -> first sub_challenge 0x01; model out=challenge[0] -> response bit 15 = 1, bit 14 = 0.
REQ-037 TIMEOUT_CYCLES=50, sub_done never asserted -> each RUN lasts 50 cycles; response=16'h0000; timeout_err=1; resp_valid asserted.
REQ-038 resp_ready held 0 for 20 cycles in HOLD, start pulsed meanwhile -> resp_valid and response stable; start ignored; IDLE one cycle after resp_ready=1.
REQ-039 reset=0 during the 5th RUN -> same-cycle outputs at REQ-032 values; resp_valid never asserts; next start restarts from seed.
REQ-040 sub_done rising on the timeout cycle -> bit captured from sub_out; timeout_err stays 0.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
// Sequences challenges into a ring-oscillator PUF subblock, one race per response bit,
// and collects the synchronized race results into a response word with a per-bit timeout.
module puf_challenge_sequencer #(
  parameter int unsigned RESP_BITS      = 16,
  parameter int unsigned CLEAR_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [7:0]           seed_i,
  output logic                 busy_o,
  output logic [31:0]          sub_enable_o,
  output logic [7:0]           sub_challenge_o,
  output logic                 sub_reset_o,
  input  logic                 sub_out_i,
  input  logic                 sub_done_i,
  output logic [RESP_BITS-1:0] response_o,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 timeout_err_o
);

  localparam logic [5:0]  LAST_BIT  = 6'(RESP_BITS - 1);
  localparam logic [15:0] CLR_LAST  = 16'(CLEAR_CYCLES - 1);
  localparam logic [19:0] TO_LAST   = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_NEXT  = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           clr_cnt_q, clr_cnt_d;
  logic [19:0]           timer_q, timer_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            chal_q, chal_d;
  logic [RESP_BITS-1:0]  resp_q, resp_d;
  logic                  terr_q, terr_d;
  logic                  busy_q, busy_d;
  logic [31:0]           en_q, en_d;
  logic                  srst_q, srst_d;
  logic                  valid_q, valid_d;
  logic                  done_meta_q, done_s_q;
  logic                  out_meta_q, out_s_q;

  function automatic logic lfsr_fb(input logic [7:0] c);
    return c[7] ^ c[5] ^ c[4] ^ c[3];
  endfunction

  // Two-flop synchronizers for the asynchronous race result and done flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_meta_q <= 1'b0;
      done_s_q    <= 1'b0;
      out_meta_q  <= 1'b0;
      out_s_q     <= 1'b0;
    end else begin
      done_meta_q <= sub_done_i;
      done_s_q    <= done_meta_q;
      out_meta_q  <= sub_out_i;
      out_s_q     <= out_meta_q;
    end
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    chal_d    = chal_q;
    resp_d    = resp_q;
    terr_d    = terr_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          chal_d    = (seed_i == 8'h00) ? 8'h01 : seed_i;
          bit_cnt_d = 6'd0;
          resp_d    = '0;
          terr_d    = 1'b0;
          clr_cnt_d = 16'd0;
          state_d   = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = 16'd0;
          timer_d   = 20'd0;
          state_d   = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        // A race finishing on the last allowed cycle still counts as a real bit
        if (done_s_q) begin
          resp_d  = {resp_q[RESP_BITS-2:0], out_s_q};
          state_d = S_NEXT;
        end else if (timer_q == TO_LAST) begin
          resp_d  = {resp_q[RESP_BITS-2:0], 1'b0};
          terr_d  = 1'b1;
          state_d = S_NEXT;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end
      S_NEXT: begin
        chal_d    = {chal_q[6:0], lfsr_fb(chal_q)};
        bit_cnt_d = bit_cnt_q + 6'd1;
        clr_cnt_d = 16'd0;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_HOLD: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d  = (state_d != S_IDLE);
    en_d    = (state_d == S_RUN) ? 32'hFFFF_FFFF : 32'h0000_0000;
    srst_d  = (state_d == S_CLEAR);
    valid_d = (state_d == S_HOLD);
  end

  // State, datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      clr_cnt_q <= 16'd0;
      timer_q   <= 20'd0;
      bit_cnt_q <= 6'd0;
      chal_q    <= 8'h00;
      resp_q    <= '0;
      terr_q    <= 1'b0;
      busy_q    <= 1'b0;
      en_q      <= 32'h0000_0000;
      srst_q    <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      chal_q    <= chal_d;
      resp_q    <= resp_d;
      terr_q    <= terr_d;
      busy_q    <= busy_d;
      en_q      <= en_d;
      srst_q    <= srst_d;
      valid_q   <= valid_d;
    end
  end

  assign busy_o          = busy_q;
  assign sub_enable_o    = en_q;
  assign sub_challenge_o = chal_q;
  assign sub_reset_o     = srst_q;
  assign response_o      = resp_q;
  assign resp_valid_o    = valid_q;
  assign timeout_err_o   = terr_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench: a behavioural PUF subblock with per-bit race delays, table-driven
// and randomized requests, plus hand-written hold, reset and boundary sequences.
module tb_puf_challenge_sequencer;

  localparam int RB = 16;
  localparam int CC = 4;
  localparam int TO = 50;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [7:0]    seed_i = 8'h00;
  logic          busy_o;
  logic [31:0]   sub_enable_o;
  logic [7:0]    sub_challenge_o;
  logic          sub_reset_o;
  logic          sub_out_i = 1'b0;
  logic          sub_done_i = 1'b0;
  logic [RB-1:0] response_o;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b0;
  logic          timeout_err_o;

  puf_challenge_sequencer #(.RESP_BITS(RB), .CLEAR_CYCLES(CC), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .seed_i(seed_i), .busy_o(busy_o),
    .sub_enable_o(sub_enable_o), .sub_challenge_o(sub_challenge_o), .sub_reset_o(sub_reset_o),
    .sub_out_i(sub_out_i), .sub_done_i(sub_done_i), .response_o(response_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .timeout_err_o(timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Subblock model: race for bit i finishes delay_cfg[i] enabled cycles after enable
  int         delay_cfg [RB];
  logic       out_cfg   [RB];
  int         run_len   [RB];
  int         out_mode = 1;   // 0/1: constant, 2: challenge[0], 3: out_cfg per bit
  int         run_cnt = 0;
  int         idx;
  logic [7:0] seen [$];

  always @(negedge clk_i) begin
    if (!rst_ni || sub_reset_o) begin
      sub_done_i = 1'b0;
      sub_out_i  = 1'b0;
      run_cnt    = 0;
    end else if (sub_enable_o == 32'hFFFF_FFFF) begin
      if (run_cnt == 0) seen.push_back(sub_challenge_o);
      run_cnt++;
      idx = seen.size() - 1;
      if (idx < RB) begin
        run_len[idx] = run_cnt;
        if (!sub_done_i && run_cnt >= delay_cfg[idx]) begin
          sub_done_i = 1'b1;
          case (out_mode)
            0:       sub_out_i = 1'b0;
            1:       sub_out_i = 1'b1;
            2:       sub_out_i = sub_challenge_o[0];
            default: sub_out_i = out_cfg[idx];
          endcase
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] c);
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

  task automatic set_cfg(input int d, input int mode);
    for (int i = 0; i < RB; i++) begin
      delay_cfg[i] = d;
      out_cfg[i]   = (mode == 1);
    end
    out_mode = mode;
  endtask

  task automatic do_req(input logic [7:0] sd, input logic [RB-1:0] exp_r, input logic exp_e,
                        input bit ack);
    logic [7:0] c;
    int cyc;
    seen.delete();
    @(negedge clk_i);
    seed_i  = sd;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    seed_i  = ~sd;
    chk("busy_after_start", {31'd0, busy_o}, 32'd1);
    cyc = 0;
    while (!resp_valid_o && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("resp_valid_seen", {31'd0, resp_valid_o}, 32'd1);
    chk("response", {16'd0, response_o}, {16'd0, exp_r});
    chk("timeout_err", {31'd0, timeout_err_o}, {31'd0, exp_e});
    chk("bit_count", seen.size(), RB);
    c = (sd == 8'h00) ? 8'h01 : sd;
    for (int i = 0; i < RB; i++) begin
      if (i < seen.size()) chk("challenge", {24'd0, seen[i]}, {24'd0, c});
      c = lfsr_next(c);
    end
    if (ack) begin
      resp_ready_i = 1'b1;
      @(negedge clk_i);
      resp_ready_i = 1'b0;
      chk("valid_drop", {31'd0, resp_valid_o}, 32'd0);
      chk("idle_busy", {31'd0, busy_o}, 32'd0);
    end
  endtask

  typedef struct {
    logic [7:0]    seed;
    int            delay;
    int            mode;
    logic [RB-1:0] resp;
    logic          err;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [RB-1:0] er;
    logic          ee;
    logic [7:0]    sd;
    bit            ok;
    int            cyc;

    tbl[0] = '{8'h01, 10,   1, 16'hFFFF, 1'b0};
    tbl[1] = '{8'h00, 10,   2, 16'h8E25, 1'b0};
    tbl[2] = '{8'h01, 1000, 1, 16'h0000, 1'b1};
    tbl[3] = '{8'hC3, 48,   1, 16'hFFFF, 1'b0};
    tbl[4] = '{8'h7E, 49,   1, 16'h0000, 1'b1};
    tbl[5] = '{8'hA5, 3,    0, 16'h0000, 1'b0};

    // Reset state while reset is held, then sub_reset falls on the first edge
    set_cfg(10, 1);
    #12;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_sub_reset", {31'd0, sub_reset_o}, 32'd1);
    chk("rst_enable", sub_enable_o, 32'd0);
    chk("rst_challenge", {24'd0, sub_challenge_o}, 32'd0);
    chk("rst_response", {16'd0, response_o}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("idle_sub_reset", {31'd0, sub_reset_o}, 32'd0);
    chk("idle_busy0", {31'd0, busy_o}, 32'd0);

    // Table rows; RUN lasts (delay + 2 sync) cycles, capped at TO by the timeout
    for (int r = 0; r < 6; r++) begin
      set_cfg(tbl[r].delay, tbl[r].mode);
      do_req(tbl[r].seed, tbl[r].resp, tbl[r].err, 1'b1);
      chk("run_len", run_len[0], (tbl[r].delay + 2 < TO) ? tbl[r].delay + 2 : TO);
    end

    // Randomized requests against the per-bit rule: bit kept iff done_s appears in time
    for (int n = 0; n < 6; n++) begin
      sd = 8'($urandom);
      out_mode = 3;
      er = '0;
      ee = 1'b0;
      for (int i = 0; i < RB; i++) begin
        delay_cfg[i] = $urandom_range(1, 55);
        out_cfg[i]   = 1'($urandom_range(0, 1));
        er = {er[RB-2:0], (delay_cfg[i] + 1 <= TO - 1) ? out_cfg[i] : 1'b0};
        ee = ee | (delay_cfg[i] + 1 > TO - 1);
      end
      do_req(sd, er, ee, 1'b1);
    end

    // HOLD with resp_ready low for 20 cycles and a start pulse in the middle
    set_cfg(5, 1);
    do_req(8'h33, 16'hFFFF, 1'b0, 1'b0);
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      start_i = (k == 5);
      if (resp_valid_o !== 1'b1 || response_o !== 16'hFFFF || timeout_err_o !== 1'b0) ok = 1'b0;
    end
    start_i = 1'b0;
    chk("hold_stable", {31'd0, ok}, 32'd1);
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    chk("hold_exit_valid", {31'd0, resp_valid_o}, 32'd0);
    repeat (5) @(negedge clk_i);
    chk("hold_start_ignored", {31'd0, busy_o}, 32'd0);

    // Reset during the 5th RUN abandons the request
    set_cfg(10, 1);
    seen.delete();
    @(negedge clk_i);
    seed_i  = 8'h5A;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 0;
    while (seen.size() < 5 && cyc < 2000) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("reached_run5", seen.size(), 5);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_enable", sub_enable_o, 32'd0);
    chk("mid_challenge", {24'd0, sub_challenge_o}, 32'd0);
    chk("mid_sub_reset", {31'd0, sub_reset_o}, 32'd1);
    chk("mid_response", {16'd0, response_o}, 32'd0);
    chk("mid_terr", {31'd0, timeout_err_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk_i);
      if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) ok = 1'b0;
    end
    chk("abandoned_no_valid", {31'd0, ok}, 32'd1);
    do_req(8'h5A, 16'hFFFF, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
